hdlc_rx_deframer: RTL and testbench

Serial front end of the HDLC receive channel. Takes the raw Rx bit stream (one bit per Clk) and detects flags (0111_1110) and aborts (0 followed by seven 1s). It removes stuffed zeros, assembles LSB-first data bytes and produces frame-level status. Its outputs (Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal, Rx_EoF, Rx_FrameError) feed the Rx buffer/status register stage.

---
 rtl/hdlc_rx_deframer.sv | 154 +++++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive front end: flag/abort detection on an 8-bit window, zero
// de-stuffing, LSB-first byte assembly and frame-level status pulses.
`timescale 1ns/1ps
module hdlc_rx_deframer #(
  parameter logic [7:0] FLAG_PATTERN = 8'h7E,
  parameter int         ABORT_ONES   = 7
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_AbortSignal,
  output logic [7:0] Rx_Data,
  output logic       Rx_WrByte,
  output logic       Rx_EoF,
  output logic       Rx_FrameError
);
  // state  | meaning
  // S_IDLE | hunting for an opening flag
  // S_SYNC | flag seen, waiting out the flag bits still in the window
  // S_FRAME| delivering de-stuffed data bits
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_FRAME} state_t;

  localparam int            OW       = $clog2(ABORT_ONES + 2);
  localparam logic [OW-1:0] ONES_TC  = OW'(ABORT_ONES);
  localparam logic [OW-1:0] ONES_SAT = OW'(ABORT_ONES + 1);

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_win;
  logic            r_dbit;
  logic [OW-1:0]   r_ones;
  logic            r_flag, r_abort;
  logic [2:0]      r_tmr;
  logic [2:0]      r_run;
  logic [2:0]      r_bcnt;
  logic [6:0]      r_sh;
  logic [7:0]      r_data;
  logic            r_wr, r_eof, r_fe, r_abort_sig, r_wrote;

  logic w_flag_win, w_abort_win, w_drop;
  logic w_tmr_load, w_deliver, w_eof, w_fe, w_abort_sig, w_valid;

  assign w_flag_win  = (r_win == FLAG_PATTERN);
  assign w_abort_win = (r_ones == ONES_TC);
  assign w_drop      = !r_dbit && (r_run == 3'd5);

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_deliver   = 1'b0;
    w_eof       = 1'b0;
    w_fe        = 1'b0;
    w_abort_sig = 1'b0;
    if (!RxEN) begin
      w_state_nxt = S_IDLE;
    end else if (r_abort) begin
      w_state_nxt = S_IDLE;
      w_abort_sig = (r_state == S_FRAME);
    end else if (r_flag) begin
      w_state_nxt = S_SYNC;
      w_tmr_load  = 1'b1;
      if (r_state == S_FRAME) begin
        w_eof = 1'b1;
        w_fe  = (r_bcnt != 3'd0) || !r_wrote;
      end
    end else begin
      case (r_state)
        S_SYNC: begin
          if (r_tmr == 3'd0) begin
            w_state_nxt = S_FRAME;
            w_deliver   = 1'b1;
          end
        end
        S_FRAME: w_deliver = 1'b1;
        default: ;
      endcase
    end
  end

  // The sync terminal cycle already carries the first data bit, so it counts as in-frame.
  assign w_valid = (r_state == S_FRAME) ||
                   ((r_state == S_SYNC) && (r_tmr == 3'd0) && !r_flag && !r_abort);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_win       <= '1;
      r_dbit      <= 1'b0;
      r_ones      <= '0;
      r_flag      <= 1'b0;
      r_abort     <= 1'b0;
      r_tmr       <= 3'd0;
      r_run       <= 3'd0;
      r_bcnt      <= 3'd0;
      r_sh        <= 7'd0;
      r_data      <= 8'h00;
      r_wr        <= 1'b0;
      r_eof       <= 1'b0;
      r_fe        <= 1'b0;
      r_abort_sig <= 1'b0;
      r_wrote     <= 1'b0;
    end else begin
      r_win   <= {Rx, r_win[7:1]};
      r_dbit  <= r_win[0];
      if (!Rx)                    r_ones <= '0;
      else if (r_ones != ONES_SAT) r_ones <= r_ones + 1'b1;
      r_flag  <= RxEN && w_flag_win && !w_abort_win;
      r_abort <= RxEN && w_abort_win;

      if (w_tmr_load)                            r_tmr <= 3'd7;
      else if (r_state == S_SYNC && r_tmr != 0)  r_tmr <= r_tmr - 3'd1;

      r_wr <= 1'b0;
      if (w_tmr_load || w_state_nxt == S_IDLE) begin
        r_run   <= 3'd0;
        r_bcnt  <= 3'd0;
        r_wrote <= 1'b0;
      end else if (w_deliver) begin
        if (w_drop) begin
          r_run <= 3'd0;
        end else begin
          r_run  <= r_dbit ? r_run + 3'd1 : 3'd0;
          r_sh   <= {r_dbit, r_sh[6:1]};
          r_bcnt <= r_bcnt + 3'd1;
          if (r_bcnt == 3'd7) begin
            r_data  <= {r_dbit, r_sh};
            r_wr    <= 1'b1;
            r_wrote <= 1'b1;
          end
        end
      end

      r_eof       <= w_eof;
      r_fe        <= w_fe;
      r_abort_sig <= w_abort_sig;
    end
  end

  assign Rx_FlagDetect  = r_flag;
  assign Rx_AbortDetect = r_abort;
  assign Rx_ValidFrame  = w_valid;
  assign Rx_AbortSignal = r_abort_sig;
  assign Rx_Data        = r_data;
  assign Rx_WrByte      = r_wr;
  assign Rx_EoF         = r_eof;
  assign Rx_FrameError  = r_fe;
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Self-checking bench for hdlc_rx_deframer: directed and random bit streams
// compared cycle by cycle against a stream-parsing reference model.
`timescale 1ns/1ps
module tb_hdlc_rx_deframer;
  localparam int MAXN = 2048;

  logic       Clk, Rst, Rx, RxEN;
  logic       Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal;
  logic [7:0] Rx_Data;
  logic       Rx_WrByte, Rx_EoF, Rx_FrameError;

  hdlc_rx_deframer dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_AbortSignal(Rx_AbortSignal),
    .Rx_Data(Rx_Data), .Rx_WrByte(Rx_WrByte), .Rx_EoF(Rx_EoF),
    .Rx_FrameError(Rx_FrameError)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total, bad;
  bit s_bits[$];
  int stuff_run;
  logic [7:0] fp;
  bit ef[MAXN], ea[MAXN], ev[MAXN], es[MAXN], ew[MAXN], ee[MAXN], efe[MAXN];
  logic [7:0] wd[MAXN], ed[MAXN];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put_raw(input bit b);
    s_bits.push_back(b);
    stuff_run = b ? stuff_run + 1 : 0;
  endtask

  task automatic put_data_bit(input bit b);
    put_raw(b);
    if (stuff_run == 5) put_raw(1'b0);
  endtask

  task automatic put_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) put_data_bit(v[k]);
  endtask

  task automatic put_flag();
    for (int k = 0; k < 8; k++) put_raw(fp[k]);
  endtask

  task automatic put_ones(input int n);
    for (int k = 0; k < n; k++) put_raw(1'b1);
  endtask

  task automatic put_abort();
    put_raw(1'b0);
    put_ones(7 + $urandom_range(0, 2));
  endtask

  // Reference: find flags/aborts in the raw stream, then derive each frame's
  // bytes and status from the bits lying between consecutive events.
  task automatic build_model();
    int n, run, cnt, nb, nf, na, last, stopi, p;
    bit b, match, is_flag;
    logic [7:0] sh, cur;
    int fl[$], ab[$];
    n = s_bits.size();
    for (int i = 0; i < MAXN; i++) begin
      ef[i] = 0; ea[i] = 0; ev[i] = 0; es[i] = 0; ew[i] = 0; ee[i] = 0; efe[i] = 0;
      wd[i] = 8'h00; ed[i] = 8'h00;
    end
    run = 0;
    for (int j = 0; j < n; j++) begin
      run = s_bits[j] ? run + 1 : 0;
      if (run == 7) ab.push_back(j);
      if (j >= 7) begin
        match = 1;
        for (int k = 0; k < 8; k++) if (s_bits[j-7+k] != fp[k]) match = 0;
        if (match) fl.push_back(j);
      end
    end
    foreach (ab[x]) if (ab[x] + 1 < n) ea[ab[x]+1] = 1;
    foreach (fl[x]) if (fl[x] + 1 < n) ef[fl[x]+1] = 1;
    foreach (fl[x]) begin
      p = fl[x]; nf = -1; na = -1;
      if (x + 1 < fl.size()) nf = fl[x+1];
      foreach (ab[y]) if (na < 0 && ab[y] > p) na = ab[y];
      if (nf < 0 && na < 0) continue;
      is_flag = (nf >= 0) && (na < 0 || nf < na);
      stopi = is_flag ? nf - 8 : na - 8;
      if (stopi < p + 1) continue;
      last = is_flag ? nf + 1 : na + 1;
      for (int c = p + 9; c <= last; c++) if (c < n) ev[c] = 1;
      run = 0; cnt = 0; nb = 0; sh = 8'h00;
      for (int q = p + 1; q <= stopi; q++) begin
        b = s_bits[q];
        if (!b && run == 5) begin run = 0; continue; end
        run = b ? run + 1 : 0;
        sh = {b, sh[7:1]};
        cnt++;
        if (cnt == 8) begin
          cnt = 0; nb++;
          if (q + 9 < n) begin ew[q+9] = 1; wd[q+9] = sh; end
        end
      end
      if (is_flag) begin
        if (nf + 2 < n) begin ee[nf+2] = 1; efe[nf+2] = (cnt != 0) || (nb == 0); end
      end else if (na + 2 < n) begin
        es[na+2] = 1;
      end
    end
    cur = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (ew[i]) cur = wd[i];
      ed[i] = cur;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b0; RxEN = 1'b1; Rx = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outputs",
          {1'b0, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal,
           Rx_WrByte, Rx_EoF, Rx_FrameError, Rx_Data}, 16'h0000);
    Rst = 1'b1;
  endtask

  task automatic run_stream(input string name);
    logic [15:0] got, exp;
    if (s_bits.size() > MAXN - 4) begin
      $display("FAIL %s stream too long got=%0d exp<=%0d", name, s_bits.size(), MAXN - 4);
      $fatal(1, "stream overflow");
    end
    build_model();
    do_reset();
    for (int i = 0; i < s_bits.size(); i++) begin
      Rx = s_bits[i];
      @(posedge Clk);
      #1;
      got = {1'b0, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal,
             Rx_WrByte, Rx_EoF, Rx_FrameError, Rx_Data};
      exp = {1'b0, ef[i], ea[i], ev[i], es[i], ew[i], ee[i], efe[i], ed[i]};
      check($sformatf("%s c%0d", name, i), got, exp);
    end
  endtask

  task automatic gen_random();
    int nseg, kind, nbytes, extra;
    s_bits.delete(); stuff_run = 0;
    put_ones($urandom_range(0, 9));
    nseg = $urandom_range(3, 7);
    for (int s = 0; s < nseg; s++) begin
      put_flag();
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        nbytes = $urandom_range(0, 3);
        for (int b = 0; b < nbytes; b++)
          put_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
        extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        for (int b = 0; b < extra; b++) put_data_bit(1'($urandom_range(0, 1)));
      end else if (kind < 8) begin
        nbytes = $urandom_range(0, 2);
        for (int b = 0; b < nbytes; b++) put_byte(8'($urandom));
        if ($urandom_range(0, 1) == 1) put_data_bit(1'b1);
        put_abort();
      end
    end
    put_flag();
    put_ones(10);
  endtask

  initial begin
    int nflag, neof, nasig;
    bit low_pulse;
    total = 0; bad = 0; fp = 8'h7E;
    Rst = 1'b0; RxEN = 1'b1; Rx = 1'b1;

    s_bits.delete(); stuff_run = 0;
    put_ones(20);
    run_stream("idle");

    s_bits.delete(); stuff_run = 0;
    put_flag(); put_byte(8'hA5); put_byte(8'h3C); put_flag(); put_ones(10);
    run_stream("a5_3c");

    s_bits.delete(); stuff_run = 0;
    put_flag(); put_byte(8'h1F); put_byte(8'hF8); put_flag(); put_ones(10);
    run_stream("stuffed");

    s_bits.delete(); stuff_run = 0;
    put_flag(); put_byte(8'hA5); put_raw(1'b0); put_ones(7); put_ones(3);
    run_stream("abort");

    s_bits.delete(); stuff_run = 0;
    put_flag(); put_byte(8'hA5);
    put_data_bit(1'b0); put_data_bit(1'b1); put_data_bit(1'b1);
    put_flag(); put_ones(10);
    run_stream("frame_err");

    for (int r = 0; r < 10; r++) begin
      gen_random();
      run_stream($sformatf("rand%0d", r));
    end

    // Back-to-back flags, then receiver disabled part-way into the frame.
    s_bits.delete(); stuff_run = 0;
    put_flag(); put_flag(); put_flag(); put_byte(8'hA5); put_byte(8'h3C); put_ones(16);
    do_reset();
    nflag = 0; neof = 0; nasig = 0; low_pulse = 0;
    for (int i = 0; i < s_bits.size(); i++) begin
      if (i == 37) RxEN = 1'b0;
      Rx = s_bits[i];
      @(posedge Clk);
      #1;
      if (i < 37) begin
        nflag += int'(Rx_FlagDetect);
        neof  += int'(Rx_EoF);
        nasig += int'(Rx_AbortSignal);
      end else begin
        low_pulse |= Rx_FlagDetect | Rx_AbortDetect | Rx_WrByte | Rx_EoF |
                     Rx_AbortSignal | Rx_FrameError | Rx_ValidFrame;
      end
      if (i == 36) check("en_valid_before_drop", 16'(Rx_ValidFrame), 16'd1);
      if (i == 37) check("en_valid_after_drop",
                         16'({Rx_ValidFrame, Rx_EoF, Rx_AbortSignal}), 16'd0);
    end
    check("b2b_flag_count", 16'(nflag), 16'd3);
    check("b2b_no_eof", 16'(neof), 16'd0);
    check("b2b_no_abort_sig", 16'(nasig), 16'd0);
    check("en_low_quiet", 16'(low_pulse), 16'd0);
    RxEN = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
